// File: rtl/cim_tile_model.sv
// cim_tile_model: cycle-accurate behavioural model of one CIM crossbar tile.
// Inputs are written over a narrow bus into an input buffer, weights are written one crossbar
// row at a time, and i_start runs a matrix-vector product one row per cycle. Results are
// latched into an output buffer and read combinationally through an address.
//
// Ports:
//   clk, rst       single clock, synchronous active-high reset
//   i_we/i_addr/i_data          input-buffer write (ignored while busy)
//   i_start        start compute (idle only)
//   o_ready        tile idle, o_data holds the latest results
//   i_w_we/i_w_row/i_w_data     weight-row write (ignored while busy)
//   i_obuf_addr    output-buffer read address
//   o_data         NUM_CHANNELS result elements for i_obuf_addr
module cim_tile_model #(
    parameter int unsigned XBAR_SIZE         = 512,
    parameter int unsigned DATA_SIZE         = 8,
    parameter int unsigned BUS_WIDTH         = 16,
    parameter int unsigned OBUF_DATA_SIZE    = (DATA_SIZE == 1) ? $clog2(XBAR_SIZE)
                                               : 2 * DATA_SIZE + $clog2(XBAR_SIZE),
    parameter int unsigned NUM_CHANNELS      = 1,
    parameter int unsigned ELEMENTS_PER_TILE = XBAR_SIZE / DATA_SIZE,
    parameter int unsigned NUM_ADDR_IN       = XBAR_SIZE * DATA_SIZE / BUS_WIDTH,
    parameter int unsigned NUM_ADDR_OBUF     = (ELEMENTS_PER_TILE + NUM_CHANNELS - 1)
                                               / NUM_CHANNELS,
    localparam int unsigned IN_AW = (NUM_ADDR_IN > 1) ? $clog2(NUM_ADDR_IN) : 1,
    localparam int unsigned ROW_W = $clog2(XBAR_SIZE),
    localparam int unsigned OB_AW = (NUM_ADDR_OBUF > 1) ? $clog2(NUM_ADDR_OBUF) : 1,
    localparam int unsigned ROW_BITS = ELEMENTS_PER_TILE * DATA_SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_we,
    input  logic [IN_AW-1:0]          i_addr,
    input  logic [BUS_WIDTH-1:0]      i_data,
    input  logic                      i_start,
    output logic                      o_ready,
    input  logic                      i_w_we,
    input  logic [ROW_W-1:0]          i_w_row,
    input  logic [ROW_BITS-1:0]       i_w_data,
    input  logic [OB_AW-1:0]          i_obuf_addr,
    output logic [OBUF_DATA_SIZE-1:0] o_data [NUM_CHANNELS-1:0]
);

    localparam int unsigned EPW = BUS_WIDTH / DATA_SIZE;  // elements per bus word

    typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

    state_e                    r_state;
    logic [ROW_W-1:0]          r_row;
    logic                      r_ready;
    logic [BUS_WIDTH-1:0]      r_in   [NUM_ADDR_IN];
    logic [ROW_BITS-1:0]       r_w    [XBAR_SIZE];
    logic [OBUF_DATA_SIZE-1:0] r_acc  [ELEMENTS_PER_TILE];
    logic [OBUF_DATA_SIZE-1:0] r_obuf [ELEMENTS_PER_TILE];

    logic [DATA_SIZE-1:0]      w_in_elems [XBAR_SIZE];
    logic [DATA_SIZE-1:0]      w_in_elem;
    logic [ROW_BITS-1:0]       w_w_row;
    logic [2*DATA_SIZE-1:0]    w_prod [ELEMENTS_PER_TILE];
    logic [OBUF_DATA_SIZE-1:0] w_obuf_rows [1 << OB_AW][NUM_CHANNELS-1:0];
    logic                      w_idle;

    assign w_idle  = (r_state == StIdle);
    assign o_ready = r_ready;

    // Unpack the bus-word input buffer into one entry per crossbar row.
    for (genvar e = 0; e < XBAR_SIZE; e++) begin : g_in_elem
        assign w_in_elems[e] = r_in[e / EPW][(e % EPW) * DATA_SIZE +: DATA_SIZE];
    end

    assign w_in_elem = w_in_elems[r_row];
    assign w_w_row   = r_w[r_row];

    always_comb begin
        for (int c = 0; c < ELEMENTS_PER_TILE; c++) begin
            w_prod[c] = {{DATA_SIZE{1'b0}}, w_in_elem}
                      * {{DATA_SIZE{1'b0}}, w_w_row[c * DATA_SIZE +: DATA_SIZE]};
        end
    end

    // Pad the output buffer to a power-of-two address space; unused slots read 0.
    for (genvar a = 0; a < (1 << OB_AW); a++) begin : g_obuf_a
        for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_obuf_k
            if (a < NUM_ADDR_OBUF && a * NUM_CHANNELS + k < ELEMENTS_PER_TILE) begin : g_on
                assign w_obuf_rows[a][k] = r_obuf[a * NUM_CHANNELS + k];
            end else begin : g_off
                assign w_obuf_rows[a][k] = '0;
            end
        end
    end

    assign o_data = w_obuf_rows[i_obuf_addr];

    // Weight memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && w_idle && i_w_we) begin
            r_w[i_w_row] <= i_w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_ready <= 1'b1;
            r_row   <= '0;
            for (int a = 0; a < NUM_ADDR_IN; a++) begin
                r_in[a] <= '0;
            end
            for (int c = 0; c < ELEMENTS_PER_TILE; c++) begin
                r_acc[c]  <= '0;
                r_obuf[c] <= '0;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    // A write on the start edge lands before row 0 is read.
                    if (i_we && 32'(i_addr) < NUM_ADDR_IN) begin
                        r_in[i_addr] <= i_data;
                    end
                    if (i_start) begin
                        r_state <= StCompute;
                        r_row   <= '0;
                        r_ready <= 1'b0;
                        for (int c = 0; c < ELEMENTS_PER_TILE; c++) begin
                            r_acc[c] <= '0;
                        end
                    end
                end
                StCompute: begin
                    for (int c = 0; c < ELEMENTS_PER_TILE; c++) begin
                        r_acc[c] <= r_acc[c] + OBUF_DATA_SIZE'(w_prod[c]);
                    end
                    r_row <= r_row + 1'b1;
                    if (r_row == ROW_W'(XBAR_SIZE - 1)) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    for (int c = 0; c < ELEMENTS_PER_TILE; c++) begin
                        r_obuf[c] <= r_acc[c];
                    end
                    r_ready <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_tile_model.sv
// tb_cim_tile_model: directed bench for cim_tile_model. Instance u_dut uses XBAR_SIZE=8,
// DATA_SIZE=4, BUS_WIDTH=8, NUM_CHANNELS=2; instance u_wrap uses DATA_SIZE=1 to exercise
// accumulator wrap and padded output-buffer reads.
module tb_cim_tile_model;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance: EPT=2, OBUF=11, NUM_ADDR_IN=4, NUM_ADDR_OBUF=1.
    logic        we, start, ready, w_we;
    logic [1:0]  addr;
    logic [7:0]  data;
    logic [2:0]  w_row;
    logic [7:0]  w_data;
    logic [0:0]  oaddr;
    logic [10:0] odata [1:0];

    // Wrap instance: EPT=8, OBUF=3, NUM_ADDR_IN=2, NUM_ADDR_OBUF=3.
    logic        b_we, b_start, b_ready, b_w_we;
    logic [0:0]  b_addr;
    logic [3:0]  b_data;
    logic [2:0]  b_w_row;
    logic [7:0]  b_w_data;
    logic [1:0]  b_oaddr;
    logic [2:0]  b_odata [2:0];

    int n_tests = 0;
    int n_fail  = 0;
    int busy;

    cim_tile_model #(
        .XBAR_SIZE   (8),
        .DATA_SIZE   (4),
        .BUS_WIDTH   (8),
        .NUM_CHANNELS(2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_we       (we),
        .i_addr     (addr),
        .i_data     (data),
        .i_start    (start),
        .o_ready    (ready),
        .i_w_we     (w_we),
        .i_w_row    (w_row),
        .i_w_data   (w_data),
        .i_obuf_addr(oaddr),
        .o_data     (odata)
    );

    cim_tile_model #(
        .XBAR_SIZE   (8),
        .DATA_SIZE   (1),
        .BUS_WIDTH   (4),
        .NUM_CHANNELS(3)
    ) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .i_we       (b_we),
        .i_addr     (b_addr),
        .i_data     (b_data),
        .i_start    (b_start),
        .o_ready    (b_ready),
        .i_w_we     (b_w_we),
        .i_w_row    (b_w_row),
        .i_w_data   (b_w_data),
        .i_obuf_addr(b_oaddr),
        .o_data     (b_odata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are held across the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_in(input logic [7:0] d);
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; addr = 2'(i); data = d;
            tick();
        end
        we = 1'b0;
    endtask

    task automatic fill_w(input logic [7:0] d);
        for (int r = 0; r < 8; r++) begin
            w_we = 1'b1; w_row = 3'(r); w_data = d;
            tick();
        end
        w_we = 1'b0;
    endtask

    // Pulse start, then count cycles with o_ready low (bounded). Optionally inject writes and a
    // second start mid-compute, or an input write on the start edge itself.
    task automatic run_main(input bit inject, input bit same_we, output int n_busy);
        start = 1'b1;
        if (same_we) begin
            we = 1'b1; addr = 2'd3; data = 8'h22;
        end
        tick();
        start = 1'b0; we = 1'b0;
        n_busy = 0;
        while (!ready && n_busy < 50) begin
            if (inject && n_busy == 3) begin
                we = 1'b1; addr = 2'd0; data = 8'hFF;
                w_we = 1'b1; w_row = 3'd0; w_data = 8'hFF;
                start = 1'b1;
            end else begin
                we = 1'b0; w_we = 1'b0; start = 1'b0;
            end
            n_busy++;
            tick();
        end
        we = 1'b0; w_we = 1'b0; start = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [10:0] e0, input logic [10:0] e1);
        oaddr = 1'b0;
        #1;
        check_eq({tag, " out0"}, 32'(odata[0]), 32'(e0));
        check_eq({tag, " out1"}, 32'(odata[1]), 32'(e1));
    endtask

    task automatic run_wrap(output int n_busy);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n_busy = 0;
        while (!b_ready && n_busy < 50) begin
            n_busy++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        we = 0; addr = 0; data = 0; start = 0; w_we = 0; w_row = 0; w_data = 0; oaddr = 0;
        b_we = 0; b_addr = 0; b_data = 0; b_start = 0; b_w_we = 0; b_w_row = 0; b_w_data = 0;
        b_oaddr = 0;
        repeat (2) tick();

        // Reset state
        check_eq("reset ready", 32'(ready), 32'd1);
        check_eq("reset wrap ready", 32'(b_ready), 32'd1);
        check_out("reset", 11'd0, 11'd0);
        rst = 1'b0;

        // Basic MVM: inputs all 1, col0 weight 1, col1 weight 15
        fill_w(8'hF1);
        fill_in(8'h11);
        run_main(1'b0, 1'b0, busy);
        check_eq("basic busy", 32'(busy), 32'd9);
        check_out("basic", 11'd8, 11'd120);
        oaddr = 1'b1;
        #1;
        check_eq("obuf addr1 ch0", 32'(odata[0]), 32'd0);
        check_eq("obuf addr1 ch1", 32'(odata[1]), 32'd0);

        // Busy rejection: writes and start mid-compute must be dropped
        run_main(1'b1, 1'b0, busy);
        check_eq("busy busy", 32'(busy), 32'd9);
        check_out("busy", 11'd8, 11'd120);
        tick();
        check_eq("busy no restart a", 32'(ready), 32'd1);
        tick();
        check_eq("busy no restart b", 32'(ready), 32'd1);
        run_main(1'b0, 1'b0, busy);
        check_out("busy state kept", 11'd8, 11'd120);

        // Same-edge write + start: elements 6,7 become 2
        run_main(1'b0, 1'b1, busy);
        check_eq("same-edge busy", 32'(busy), 32'd9);
        check_out("same-edge", 11'd10, 11'd150);
        fill_in(8'h11);

        // Max values: 8 * 15 * 15
        fill_in(8'hFF);
        fill_w(8'hFF);
        run_main(1'b0, 1'b0, busy);
        check_out("max", 11'd1800, 11'd1800);

        // Reset mid-compute at row 4
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check_eq("pre-reset busy", 32'(ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort ready", 32'(ready), 32'd1);
        check_out("abort", 11'd0, 11'd0);
        // Input buffer was cleared; weights were kept
        run_main(1'b0, 1'b0, busy);
        check_eq("post-reset busy", 32'(busy), 32'd9);
        check_out("post-reset zero in", 11'd0, 11'd0);
        fill_in(8'h11);
        fill_w(8'hF1);
        run_main(1'b0, 1'b0, busy);
        check_out("post-reset rerun", 11'd8, 11'd120);

        // DATA_SIZE=1: all ones gives 8 mod 8 = 0 per column
        for (int i = 0; i < 2; i++) begin
            b_we = 1'b1; b_addr = 1'(i); b_data = 4'hF;
            tick();
        end
        b_we = 1'b0;
        for (int r = 0; r < 8; r++) begin
            b_w_we = 1'b1; b_w_row = 3'(r); b_w_data = 8'hFF;
            tick();
        end
        b_w_we = 1'b0;
        run_wrap(busy);
        check_eq("wrap busy", 32'(busy), 32'd9);
        for (int a = 0; a < 4; a++) begin
            b_oaddr = 2'(a);
            #1;
            for (int k = 0; k < 3; k++) begin
                check_eq($sformatf("wrap ones a%0d k%0d", a, k), 32'(b_odata[k]), 32'd0);
            end
        end

        // Row r drives only columns c > r, so column c sums to c
        for (int r = 0; r < 8; r++) begin
            logic [7:0] wv;
            wv = 8'hFF << (r + 1);
            b_w_we = 1'b1; b_w_row = 3'(r); b_w_data = wv;
            tick();
        end
        b_w_we = 1'b0;
        run_wrap(busy);
        for (int a = 0; a < 4; a++) begin
            b_oaddr = 2'(a);
            #1;
            for (int k = 0; k < 3; k++) begin
                int idx;
                idx = a * 3 + k;
                check_eq($sformatf("wrap ramp a%0d k%0d", a, k), 32'(b_odata[k]),
                         (idx < 8) ? 32'(idx) : 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
